psram_rd_cache: RTL and testbench

Direct-mapped 64-bit read line buffer between the AXI4 slave FSM user port and `psram_core` bus-transfer port. Read hits return buffered data without a PSRAM transaction. Read misses and all writes are forwarded to the core, with writes handled as write-through. It removes the OPI command/latency overhead for repeated reads, such as instruction fetch from PSRAM.

---
 rtl/psram_pkg.sv | 33 +++
 rtl/psram_rc_tag_arr.sv | 47 ++++
 rtl/psram_rd_cache.sv | 162 ++++++++++++++++
 tb/tb_psram_rd_cache.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM read-line cache.
// Holds the FSM state enum, bus address padding width and the cache line record.
package psram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIT   = 2'd1,
        MISS  = 2'd2,
        WRITE = 2'd3
    } psram_rd_cache_state_e;

    localparam int PSRAM_BUS_PAD_W = 6;

    // Widest tag a 32-bit byte address can carry; narrower tags are zero-extended.
    localparam int PSRAM_RC_TAG_W = 29;

    typedef struct packed {
        logic                      valid;
        logic [PSRAM_RC_TAG_W-1:0] tag;
        logic [63:0]               data;
    } psram_rc_line_t;

    function automatic logic [63:0] psram_byte_merge(input logic [63:0] old_data,
                                                     input logic [63:0] new_data,
                                                     input logic [7:0]  mask);
        logic [63:0] merged;
        for (int b = 0; b < 8; b++) begin
            merged[b*8 +: 8] = mask[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/psram_rc_tag_arr.sv
// Valid/tag/data storage for the read cache: one combinational read port,
// one write port and a flush-all that clears every valid bit.
module psram_rc_tag_arr
    import psram_pkg::*;
#(
    parameter int ENTRY_NUM = 8,
    parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [IDX_W-1:0]     rd_idx,
    output psram_rc_line_t       rd_line,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  psram_rc_line_t       wr_line
);

    logic [ENTRY_NUM-1:0]      valid;
    logic [PSRAM_RC_TAG_W-1:0] tag_mem  [ENTRY_NUM];
    logic [63:0]               data_mem [ENTRY_NUM];

    // Flush takes priority so a write landing on the same edge cannot revive a line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_line.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_line.tag;
            data_mem[wr_idx] <= wr_line.data;
        end
    end

    always_comb begin
        rd_line.valid = valid[rd_idx];
        rd_line.tag   = tag_mem[rd_idx];
        rd_line.data  = data_mem[rd_idx];
    end

endmodule

// File: rtl/psram_rd_cache.sv
// Direct-mapped 64-bit read line buffer in front of psram_core; writes go through.
// Define PSRAM_RD_CACHE_STAT_EN to add saturating hit/miss counters.
module psram_rd_cache
    import psram_pkg::*;
#(
    parameter int ENTRY_NUM  = 8,
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic                  usr_xfer_start_i,
    input  logic                  usr_wen_i,
    input  logic [ADDR_WIDTH-1:0] usr_addr_i,
    input  logic [7:0]            usr_bm_i,
    input  logic [63:0]           usr_dat_i,
    output logic [63:0]           usr_dat_o,
    output logic                  usr_done_o,
    output logic                  xfer_valid_o,
    output logic                  xfer_rdwr_o,
    output logic [31:0]           bus_addr_o,
    output logic [63:0]           bus_wr_data_o,
    output logic [7:0]            bus_wr_mask_o,
    input  logic [63:0]           bus_rd_data_i,
    input  logic                  xfer_done_i,
    output psram_rd_cache_state_e dbg_state_o
`ifdef PSRAM_RD_CACHE_STAT_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(ENTRY_NUM);

    psram_rd_cache_state_e     state, state_nxt;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      hit_done_q;
    logic [63:0]               hit_dat_q;
    logic [IDX_W-1:0]          rd_idx;
    logic [PSRAM_RC_TAG_W-1:0] lookup_tag;
    psram_rc_line_t            rd_line;
    logic                      tag_match;
    logic                      arr_wr_en;
    psram_rc_line_t            arr_wr_line;

    psram_rc_tag_arr #(.ENTRY_NUM(ENTRY_NUM), .IDX_W(IDX_W)) u_tag_arr (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (flush_i),
        .rd_idx  (rd_idx),
        .rd_line (rd_line),
        .wr_en   (arr_wr_en),
        .wr_idx  (rd_idx),
        .wr_line (arr_wr_line)
    );

    // In IDLE the array is probed with the incoming address; afterwards with the latched one.
    always_comb begin
        if (state == IDLE) begin
            rd_idx     = usr_addr_i[IDX_W-1:0];
            lookup_tag = PSRAM_RC_TAG_W'(usr_addr_i[ADDR_WIDTH-1:IDX_W]);
        end else begin
            rd_idx     = req_addr[IDX_W-1:0];
            lookup_tag = PSRAM_RC_TAG_W'(req_addr[ADDR_WIDTH-1:IDX_W]);
        end
        tag_match = rd_line.valid && (rd_line.tag == lookup_tag);

        arr_wr_en = xfer_done_i && !flush_i &&
                    (((state == MISS) && en_i) || ((state == WRITE) && tag_match));
        arr_wr_line.valid = 1'b1;
        arr_wr_line.tag   = lookup_tag;
        arr_wr_line.data  = (state == MISS) ? bus_rd_data_i
                          : psram_byte_merge(rd_line.data, bus_wr_data_o, bus_wr_mask_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (usr_xfer_start_i) begin
                    if (usr_wen_i) begin
                        state_nxt = WRITE;
                    end else if (en_i && tag_match && !flush_i) begin
                        state_nxt = HIT;
                    end else begin
                        state_nxt = MISS;
                    end
                end
            end
            HIT:          state_nxt = IDLE;
            MISS, WRITE:  if (xfer_done_i) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dbg_state_o  = state;
        xfer_valid_o = (state == MISS) || (state == WRITE);
        xfer_rdwr_o  = (state == MISS);
        usr_done_o   = hit_done_q || (xfer_valid_o && xfer_done_i);
        if (hit_done_q) begin
            usr_dat_o = hit_dat_q;
        end else if ((state == MISS) && xfer_done_i) begin
            usr_dat_o = bus_rd_data_i;
        end else begin
            usr_dat_o = '0;
        end
    end

    // Request latch and the registered hit response that gives the two-cycle hit latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr      <= '0;
            bus_addr_o    <= '0;
            bus_wr_data_o <= '0;
            bus_wr_mask_o <= '0;
            hit_done_q    <= 1'b0;
            hit_dat_q     <= '0;
        end else begin
            hit_done_q <= (state == HIT);
            if (state == HIT) begin
                hit_dat_q <= rd_line.data;
            end
            if ((state == IDLE) && usr_xfer_start_i) begin
                req_addr      <= usr_addr_i;
                bus_addr_o    <= {{PSRAM_BUS_PAD_W{1'b0}}, usr_addr_i, 3'd0};
                bus_wr_data_o <= usr_dat_i;
                bus_wr_mask_o <= usr_bm_i;
            end
        end
    end

`ifdef PSRAM_RD_CACHE_STAT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (flush_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == IDLE) begin
            if ((state_nxt == HIT) && (hit_cnt_o != 32'hFFFF_FFFF)) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if ((state_nxt == MISS) && en_i && (miss_cnt_o != 32'hFFFF_FFFF)) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psram_rd_cache.sv
// Randomized scoreboard bench for psram_rd_cache against a line-state/memory model.
// Define PSRAM_RD_CACHE_STAT_EN to also check the hit/miss counters.
module tb_psram_rd_cache;
    import psram_pkg::*;

    localparam int ENTRY_NUM  = 8;
    localparam int ADDR_WIDTH = 23;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en_i, flush_i, usr_xfer_start_i, usr_wen_i;
    logic [ADDR_WIDTH-1:0] usr_addr_i;
    logic [7:0]            usr_bm_i;
    logic [63:0]           usr_dat_i;
    logic [63:0]           usr_dat_o;
    logic                  usr_done_o, xfer_valid_o, xfer_rdwr_o;
    logic [31:0]           bus_addr_o;
    logic [63:0]           bus_wr_data_o;
    logic [7:0]            bus_wr_mask_o;
    logic [63:0]           bus_rd_data_i;
    logic                  xfer_done_i;
    psram_rd_cache_state_e dbg_state;
`ifdef PSRAM_RD_CACHE_STAT_EN
    logic [31:0]           hit_cnt, miss_cnt;
`endif

    psram_rd_cache #(.ENTRY_NUM(ENTRY_NUM), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_i             (en_i),
        .flush_i          (flush_i),
        .usr_xfer_start_i (usr_xfer_start_i),
        .usr_wen_i        (usr_wen_i),
        .usr_addr_i       (usr_addr_i),
        .usr_bm_i         (usr_bm_i),
        .usr_dat_i        (usr_dat_i),
        .usr_dat_o        (usr_dat_o),
        .usr_done_o       (usr_done_o),
        .xfer_valid_o     (xfer_valid_o),
        .xfer_rdwr_o      (xfer_rdwr_o),
        .bus_addr_o       (bus_addr_o),
        .bus_wr_data_o    (bus_wr_data_o),
        .bus_wr_mask_o    (bus_wr_mask_o),
        .bus_rd_data_i    (bus_rd_data_i),
        .xfer_done_i      (xfer_done_i),
        .dbg_state_o      (dbg_state)
`ifdef PSRAM_RD_CACHE_STAT_EN
        ,
        .hit_cnt_o        (hit_cnt),
        .miss_cnt_o       (miss_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        bit          wen;
        logic [63:0] data;
        bit          hit;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   done_cnt  = 0;

    // Reference model: memory contents plus which tag each line holds.
    logic [63:0] mem[int unsigned];
    bit          mv[ENTRY_NUM];
    int unsigned mt[ENTRY_NUM];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] mem_get(input int unsigned a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
        return mem[a];
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < ENTRY_NUM; i++) mv[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && usr_done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", usr_done_o, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.wen) check("rd_data", usr_dat_o, mon_e.data);
                if (mon_e.hit) check("hit_latency", cyc - mon_e.start_cyc, 2);
                else           check("done_with_core", xfer_done_i, 1'b1);
            end
            done_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic access(input bit wen, input int unsigned addr, input logic [7:0] bm,
                          input logic [63:0] wd, input bit en_s, input bit en_d,
                          input bit fl_s, input bit fl_d, input int lat);
        int          idx  = int'(addr % ENTRY_NUM);
        int unsigned tag  = addr / ENTRY_NUM;
        bit          hit;
        bit          seen;
        int          prev = done_cnt;
        logic [22:0] a23  = addr[22:0];
        logic [31:0] exp_baddr;
        exp_t        e;

        @(posedge clk); #1;
        usr_xfer_start_i = 1'b1;
        usr_wen_i        = wen;
        usr_addr_i       = a23;
        usr_bm_i         = bm;
        usr_dat_i        = wd;
        en_i             = en_s;
        flush_i          = fl_s;
        hit = !wen && en_s && !fl_s && mv[idx] && (mt[idx] == tag);
        e.wen = wen; e.hit = hit; e.start_cyc = cyc;
        e.data = wen ? 64'h0 : mem_get(addr);
        exp_q.push_back(e);
        if (fl_s) model_flush();
        else if (hit) exp_hits++;
        else if (!wen && en_s) exp_misses++;

        @(posedge clk); #1;
        usr_xfer_start_i = 1'b0;
        flush_i          = 1'b0;
        usr_addr_i       = 23'($urandom);
        usr_dat_i        = {$urandom, $urandom};
        usr_bm_i         = 8'($urandom);

        if (hit) begin
            seen = 1'b0;
            for (int i = 0; i < 6 && done_cnt == prev; i++) begin
                @(negedge clk);
                if (xfer_valid_o) seen = 1'b1;
            end
            check("hit_no_core", seen, 1'b0);
            if (seen) begin
                @(posedge clk); #1; xfer_done_i = 1'b1;
                @(posedge clk); #1; xfer_done_i = 1'b0;
            end
        end else begin
            exp_baddr = {6'd0, a23, 3'd0};
            @(negedge clk);
            check("xfer_valid_n1", xfer_valid_o, 1'b1);
            check("xfer_rdwr", xfer_rdwr_o, !wen);
            check("bus_addr", bus_addr_o, exp_baddr);
            if (wen) begin
                check("bus_wr_data", bus_wr_data_o, wd);
                check("bus_wr_mask", bus_wr_mask_o, bm);
            end
            repeat (lat) @(posedge clk);
            @(posedge clk); #1;
            check("xfer_valid_hold", xfer_valid_o, 1'b1);
            xfer_done_i   = 1'b1;
            bus_rd_data_i = wen ? {$urandom, $urandom} : mem_get(addr);
            flush_i       = fl_d;
            en_i          = en_d;
            if (wen) begin
                logic [63:0] old = mem_get(addr);
                for (int b = 0; b < 8; b++) if (bm[b]) old[b*8 +: 8] = wd[b*8 +: 8];
                mem[addr] = old;
            end else if (en_d && !fl_d) begin
                mv[idx] = 1'b1;
                mt[idx] = tag;
            end
            if (fl_d) model_flush();
            @(posedge clk); #1;
            xfer_done_i   = 1'b0;
            flush_i       = 1'b0;
            bus_rd_data_i = {$urandom, $urandom};
            @(negedge clk);
            check("xfer_valid_drop", xfer_valid_o, 1'b0);
        end

        for (int i = 0; i < 8 && done_cnt == prev; i++) @(negedge clk);
        if (done_cnt == prev) begin
            check("done_timeout", 1'b0, 1'b1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
    endtask

    task automatic rd(input int unsigned addr);
        access(1'b0, addr, 8'h00, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, $urandom_range(0, 3));
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1; flush_i = 1'b1;
        model_flush();
        @(posedge clk); #1; flush_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en_i = 1'b1; flush_i = 1'b0; usr_xfer_start_i = 1'b0; usr_wen_i = 1'b0;
        usr_addr_i = '0; usr_bm_i = '0; usr_dat_i = '0; bus_rd_data_i = '0; xfer_done_i = 1'b0;
        model_flush();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", usr_done_o, 1'b0);
        check("rst_xfer_valid", xfer_valid_o, 1'b0);
        check("rst_rdwr", xfer_rdwr_o, 1'b0);
        check("rst_dat", usr_dat_o, 64'h0);
        check("rst_bus", {bus_addr_o, bus_wr_mask_o, bus_wr_data_o[23:0]}, 64'h0);
        check("rst_wr_data", bus_wr_data_o, 64'h0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk); #1; rst = 1'b0;

        // Miss then hit on the same word.
        mem['h10] = 64'hDEAD_BEEF_0123_4567;
        rd('h10);
        rd('h10);
        // Same index, different tag evicts.
        rd('h18);
        rd('h10);
        // Write-through merges into the resident line.
        access(1'b1, 'h10, 8'h0F, 64'h1111_1111_2222_2222, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        rd('h10);
        // Write to a non-resident word must not allocate.
        access(1'b1, 'h28, 8'hF0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        rd('h28);
        // Explicit flush, flush racing a miss completion, flush racing a start.
        pulse_flush();
        rd('h10);
        rd('h10);
        access(1'b0, 'h18, 8'h00, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2);
        rd('h18);
        rd('h10);
        access(1'b0, 'h18, 8'h00, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        rd('h18);
        // Bypass: two reads with the cache disabled, then en falling mid-miss.
        access(1'b0, 'h20, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        access(1'b0, 'h20, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        access(1'b0, 'h20, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        rd('h20);
        rd('h20);

`ifdef PSRAM_RD_CACHE_STAT_EN
        pulse_flush();
        @(negedge clk);
        check("stat_hit_flushed", hit_cnt, 32'd0);
        check("stat_miss_flushed", miss_cnt, 32'd0);
        rd('h40); rd('h41); rd('h42);
        rd('h40); rd('h41); rd('h42); rd('h40); rd('h41);
        @(negedge clk);
        check("stat_hit_5", hit_cnt, 32'd5);
        check("stat_miss_3", miss_cnt, 32'd3);
        pulse_flush();
        @(negedge clk);
        check("stat_hit_clr", hit_cnt, 32'd0);
        check("stat_miss_clr", miss_cnt, 32'd0);
`endif

        // Randomized mix over a small address pool to force collisions.
        for (int n = 0; n < 250; n++) begin
            bit wen = ($urandom_range(0, 3) == 0);
            access(wen, $urandom_range(0, 47), 8'($urandom), {$urandom, $urandom},
                   ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                   ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                   $urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) pulse_flush();
        end

`ifdef PSRAM_RD_CACHE_STAT_EN
        @(negedge clk);
        check("stat_hit_end", hit_cnt, 32'(exp_hits));
        check("stat_miss_end", miss_cnt, 32'(exp_misses));
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
